// File: rtl/input_debouncer_pkg.sv
// debounce_pkg: filter FSM states and synchroniser depth shared by the debouncer files
package debounce_pkg;
  typedef enum logic [1:0] {ST_LOW, ST_CHK_HIGH, ST_HIGH, ST_CHK_LOW} dbn_state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/input_debouncer_if.sv
// input_debouncer_if: raw inputs and conditioned outputs; toggle present only with DEBOUNCE_TOGGLE_EN
interface input_debouncer_if #(parameter int WIDTH = 2);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
`ifdef DEBOUNCE_TOGGLE_EN
  logic [WIDTH-1:0] toggle;
  modport master(output raw_in, input level, rise, fall, toggle);
  modport slave(input raw_in, output level, rise, fall, toggle);
`else
  modport master(output raw_in, input level, rise, fall);
  modport slave(input raw_in, output level, rise, fall);
`endif
endinterface

// File: rtl/input_debouncer_bit.sv
// debounce_bit: one-bit synchroniser, stability counter and four-state filter with edge pulses
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [SYNC_STAGES-1:0] sync;
  logic s2;
  dbn_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic level_n, rise_n, fall_n;
  assign s2 = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync  <= '0;
      state <= ST_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], d};
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  // any reversal inside a check state falls back to the stable state with a cleared count
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    level_n = level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      ST_LOW:
        if (s2) begin
          state_n = ST_CHK_HIGH;
          cnt_n   = ONE;
        end
      ST_CHK_HIGH:
        if (!s2) state_n = ST_LOW;
        else if (cnt == LIMIT) begin
          state_n = ST_HIGH;
          level_n = 1'b1;
          rise_n  = 1'b1;
        end else cnt_n = cnt + ONE;
      ST_HIGH:
        if (!s2) begin
          state_n = ST_CHK_LOW;
          cnt_n   = ONE;
        end
      ST_CHK_LOW:
        if (s2) state_n = ST_HIGH;
        else if (cnt == LIMIT) begin
          state_n = ST_LOW;
          level_n = 1'b0;
          fall_n  = 1'b1;
        end else cnt_n = cnt + ONE;
      default: state_n = ST_LOW;
    endcase
  end
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: WIDTH independent debounced inputs with rise/fall pulses
// Optional toggle output enabled by defining DEBOUNCE_TOGGLE_EN.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  input_debouncer_if.slave bus
);
  logic [WIDTH-1:0] level_w, rise_w, fall_w;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES)) u_bit (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.raw_in[i]),
      .level(level_w[i]),
      .rise (rise_w[i]),
      .fall (fall_w[i])
    );
  end
  assign bus.level = level_w;
  assign bus.rise  = rise_w;
  assign bus.fall  = fall_w;
`ifdef DEBOUNCE_TOGGLE_EN
  logic [WIDTH-1:0] tog;
  always_ff @(posedge clk or posedge rst)
    if (rst) tog <= '0;
    else tog <= tog ^ rise_w;
  assign bus.toggle = tog;
`endif
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: run-length reference model plus directed debounce scenarios
module tb_input_debouncer;
  localparam int W = 2;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  input_debouncer_if #(.WIDTH(W)) bus ();
  input_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (.clk(clk), .rst(rst), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  int rc[W] = '{default: 0};
  int fc[W] = '{default: 0};
  // a bit flips once the synchronised input has differed from the level for S+1 consecutive cycles
  logic [W-1:0] m_h1, m_h2, m_level, m_rise, m_fall, m_tog;
  logic [W-1:0] n_level, n_rise, n_fall;
  int m_run[W];
  int n_run[W];
  always_comb begin
    for (int i = 0; i < W; i++) begin
      n_run[i] = (m_h2[i] != m_level[i]) ? m_run[i] + 1 : 0;
      n_rise[i] = (n_run[i] == S + 1) && !m_level[i];
      n_fall[i] = (n_run[i] == S + 1) && m_level[i];
      n_level[i] = m_level[i] ^ (n_run[i] == S + 1);
      if (n_run[i] == S + 1) n_run[i] = 0;
    end
  end
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_h1 <= '0;
      m_h2 <= '0;
      m_level <= '0;
      m_rise <= '0;
      m_fall <= '0;
      m_tog <= '0;
      m_run <= '{default: 0};
    end else begin
      m_h1 <= bus.raw_in;
      m_h2 <= m_h1;
      m_level <= n_level;
      m_rise <= n_rise;
      m_fall <= n_fall;
      m_tog <= m_tog ^ n_rise;
      m_run <= n_run;
    end
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask
  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      check("level", bus.level, m_level);
      check("rise", bus.rise, m_rise);
      check("fall", bus.fall, m_fall);
      check("rise_and_fall", bus.rise & bus.fall, 2'b00);
`ifdef DEBOUNCE_TOGGLE_EN
      check("toggle", bus.toggle, m_tog);
`endif
      for (int i = 0; i < W; i++) begin
        rc[i] <= rc[i] + int'(bus.rise[i]);
        fc[i] <= fc[i] + int'(bus.fall[i]);
      end
    end
  task automatic set(input logic [W-1:0] v);
    @(negedge clk);
    bus.raw_in = v;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  int r0, r1, f0, f1;
  initial begin
    bus.raw_in = 2'b11;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_level", bus.level, 2'b00);
    check("rst_rise", bus.rise, 2'b00);
    check("rst_fall", bus.fall, 2'b00);
    rst = 1'b0;
    step(6);
    check("t1_level_wait", bus.level, 2'b00);
    step(1);
    check("t1_level", bus.level, 2'b11);
    check("t1_rise", bus.rise, 2'b11);
    set(2'b00);
    step(12);
    set(2'b01);
    step(6);
    check("t2_level_pre", bus.level, 2'b00);
    step(1);
    check("t2_level", bus.level, 2'b01);
    check("t2_rise", bus.rise, 2'b01);
    check("t2_fall", bus.fall, 2'b00);
    check("t2_model_level", m_level, 2'b01);
    step(1);
    check("t2_rise_end", bus.rise, 2'b00);
    r1 = rc[1];
    set(2'b11);
    @(negedge clk);
    @(negedge clk);
    bus.raw_in = 2'b01;
    step(10);
    check("t3_level", bus.level, 2'b01);
    check_int("t3_rise_count", rc[1], r1);
    set(2'b00);
    step(12);
    r0 = rc[0];
    set(2'b01);
    set(2'b00);
    set(2'b01);
    set(2'b00);
    set(2'b01);
    step(6);
    check("t4_level_pre", bus.level, 2'b00);
    step(1);
    check("t4_rise", bus.rise, 2'b01);
    step(5);
    check_int("t4_rise_count", rc[0], r0 + 1);
    set(2'b00);
    step(12);
    set(2'b11);
    step(7);
    check("t5_rise", bus.rise, 2'b11);
    step(3);
    set(2'b10);
    step(7);
    check("t5_fall", bus.fall, 2'b01);
    check("t5_rise_none", bus.rise, 2'b00);
    check("t5_level", bus.level, 2'b10);
    step(3);
    r0 = rc[0];
    r1 = rc[1];
    f0 = fc[0];
    f1 = fc[1];
    set(2'b11);
    step(4);
    rst = 1'b1;
    #1;
    check("t6_rst_level", bus.level, 2'b00);
    check("t6_rst_pulses", bus.rise | bus.fall, 2'b00);
    bus.raw_in = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    step(12);
    check("t6_level", bus.level, 2'b00);
    check_int("t6_rise0", rc[0], r0);
    check_int("t6_rise1", rc[1], r1);
    check_int("t6_fall0", fc[0], f0);
    check_int("t6_fall1", fc[1], f1);
`ifdef DEBOUNCE_TOGGLE_EN
    check("t6_toggle_rst", bus.toggle, 2'b00);
    repeat (3) begin
      set(2'b01);
      step(9);
      set(2'b00);
      step(9);
    end
    check("t6_toggle", bus.toggle, 2'b01);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
